// File: rtl/SystemPkg.sv
// SystemPkg: shared width defaults and the port-index ID tagging helper
package SystemPkg;
  localparam int DEF_NUM    = 8;
  localparam int DEF_ASIZE  = 32;
  localparam int DEF_LSIZE  = 8;
  localparam int DEF_DSIZE  = 256;
  localparam int DEF_LAZISE = 4;
  function automatic logic [31:0] tag_id(input logic [31:0] id, input logic [31:0] idx, input int nsize);
    return (id << nsize) | idx;
  endfunction
endpackage

// File: rtl/rd_id_rr_arbiter.sv
// rd_id_rr_arbiter: round-robin arbiter, one-hot grant plus encoded index
module rd_id_rr_arbiter
  import SystemPkg::*;
#(
  parameter int NUM = DEF_NUM,
  localparam int NSIZE = $clog2(NUM)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [NUM-1:0]   req,
  input  logic             adv,
  output logic [NUM-1:0]   gnt,
  output logic [NSIZE-1:0] idx
);
  logic [NSIZE-1:0] last;
  logic [NSIZE-1:0] p;
  // scan farthest-first so the nearest requester after `last` is written last and wins
  always_comb begin
    gnt = '0;
    idx = '0;
    p   = '0;
    for (int i = NUM; i >= 1; i--) begin
      p = NSIZE'((int'(last) + i) % NUM);
      if (req[p]) begin
        gnt = NUM'(1) << p;
        idx = p;
      end
    end
  end
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) last <= NSIZE'(NUM - 1);
    else if (adv && |req) last <= idx;
endmodule

// File: rtl/axi4_rd_id_interconnect_m2s.sv
// axi4_rd_id_interconnect_m2s: NUM read ports onto one AXI4 read master,
// ID-tagged on AR and routed back by rid index bits on R
module axi4_rd_id_interconnect_m2s
  import SystemPkg::*;
#(
  parameter int NUM    = DEF_NUM,
  parameter int ASIZE  = DEF_ASIZE,
  parameter int LSIZE  = DEF_LSIZE,
  parameter int DSIZE  = DEF_DSIZE,
  parameter int LAZISE = DEF_LAZISE,
  localparam int NSIZE  = $clog2(NUM),
  localparam int IDSIZE = LAZISE + NSIZE
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [NUM-1:0]        s_arvalid,
  output logic [NUM-1:0]        s_arready,
  input  logic [NUM*ASIZE-1:0]  s_araddr,
  input  logic [NUM*LSIZE-1:0]  s_arlen,
  input  logic [NUM*LAZISE-1:0] s_arid,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ASIZE-1:0]      m_araddr,
  output logic [LSIZE-1:0]      m_arlen,
  output logic [IDSIZE-1:0]     m_arid,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [DSIZE-1:0]      m_rdata,
  input  logic                  m_rlast,
  input  logic [IDSIZE-1:0]     m_rid,
  output logic [NUM-1:0]        s_rvalid,
  input  logic [NUM-1:0]        s_rready,
  output logic [NUM*DSIZE-1:0]  s_rdata,
  output logic [NUM-1:0]        s_rlast,
  output logic [NUM*LAZISE-1:0] s_rid
);
  logic [NUM-1:0]    gnt;
  logic [NSIZE-1:0]  win;
  logic              ar_free;
  logic              r_valid;
  logic [DSIZE-1:0]  r_data;
  logic              r_last;
  logic [IDSIZE-1:0] r_id;
  logic [NSIZE-1:0]  k;
  logic              k_ok;
  logic              k_ready;
  assign ar_free   = !m_arvalid || m_arready;
  assign s_arready = ar_free ? gnt : '0;
  rd_id_rr_arbiter #(.NUM(NUM)) u_arb (
    .clock (clock),
    .rst_n (rst_n),
    .req   (s_arvalid),
    .adv   (ar_free),
    .gnt   (gnt),
    .idx   (win)
  );
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arid    <= '0;
    end else if (ar_free) begin
      m_arvalid <= |s_arvalid;
      if (|s_arvalid) begin
        m_araddr <= s_araddr[win*ASIZE +: ASIZE];
        m_arlen  <= s_arlen[win*LSIZE +: LSIZE];
        m_arid   <= IDSIZE'(tag_id(32'(s_arid[win*LAZISE +: LAZISE]), 32'(win), NSIZE));
      end
    end
  // an index with no matching port is treated as always ready, so the beat drains away
  assign k       = r_id[NSIZE-1:0];
  assign k_ok    = int'(k) < NUM;
  assign k_ready = !k_ok || s_rready[k];
  assign m_rready = !r_valid || k_ready;
  always_comb begin
    s_rvalid = '0;
    if (r_valid && k_ok) s_rvalid[k] = 1'b1;
  end
  assign s_rdata = {NUM{r_data}};
  assign s_rlast = {NUM{r_last}};
  assign s_rid   = {NUM{r_id[IDSIZE-1:NSIZE]}};
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_id    <= '0;
    end else if (m_rready) begin
      r_valid <= m_rvalid;
      if (m_rvalid) begin
        r_data <= m_rdata;
        r_last <= m_rlast;
        r_id   <= m_rid;
      end
    end
endmodule

// File: tb/tb_axi4_rd_id_interconnect_m2s.sv
// tb_axi4_rd_id_interconnect_m2s: directed stimulus, per-cycle model compare plus literal pins
module tb_axi4_rd_id_interconnect_m2s;
  localparam int NUM = 4, ASIZE = 32, LSIZE = 8, DSIZE = 16, LAZISE = 2, IDSIZE = 4;
  logic                  clock = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NUM-1:0]        s_arvalid, s_arready;
  logic [NUM*ASIZE-1:0]  s_araddr;
  logic [NUM*LSIZE-1:0]  s_arlen;
  logic [NUM*LAZISE-1:0] s_arid;
  logic                  m_arvalid, m_arready;
  logic [ASIZE-1:0]      m_araddr;
  logic [LSIZE-1:0]      m_arlen;
  logic [IDSIZE-1:0]     m_arid;
  logic                  m_rvalid, m_rready, m_rlast;
  logic [DSIZE-1:0]      m_rdata;
  logic [IDSIZE-1:0]     m_rid;
  logic [NUM-1:0]        s_rvalid, s_rready, s_rlast;
  logic [NUM*DSIZE-1:0]  s_rdata;
  logic [NUM*LAZISE-1:0] s_rid;
  always #5 clock = ~clock;
  axi4_rd_id_interconnect_m2s #(
    .NUM(NUM), .ASIZE(ASIZE), .LSIZE(LSIZE), .DSIZE(DSIZE), .LAZISE(LAZISE)
  ) dut (
    .clock(clock), .rst_n(rst_n),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arid(s_arid),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arid(m_arid),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rid(m_rid),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rid(s_rid)
  );
  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  // model: last granted port, pending AR request, pending R beat
  int          m_last;
  bit          m_arv, m_rv, m_rl_e;
  logic [31:0] m_addr_e;
  logic [7:0]  m_len_e;
  logic [3:0]  m_id_e, m_rid_e;
  logic [15:0] m_rd_e;
  int          w_now, k_now;
  bit          free_now, rr_now;
  function automatic int winner();
    for (int i = 1; i <= NUM; i++) begin
      int p;
      p = (m_last + i) % NUM;
      if (s_arvalid[p]) return p;
    end
    return -1;
  endfunction
  always_comb begin
    w_now    = winner();
    free_now = !m_arv || m_arready;
    k_now    = int'(m_rid_e[1:0]);
    rr_now   = !m_rv || s_rready[k_now];
  end
  always @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      m_last <= NUM - 1; m_arv <= 0; m_rv <= 0; m_rl_e <= 0;
      m_addr_e <= 0; m_len_e <= 0; m_id_e <= 0; m_rid_e <= 0; m_rd_e <= 0;
    end else begin
      if (free_now) begin
        m_arv <= (w_now >= 0);
        if (w_now >= 0) begin
          m_addr_e <= s_araddr[w_now*ASIZE +: ASIZE];
          m_len_e  <= s_arlen[w_now*LSIZE +: LSIZE];
          m_id_e   <= {s_arid[w_now*LAZISE +: LAZISE], 2'(w_now)};
          m_last   <= w_now;
        end
      end
      if (rr_now) begin
        m_rv <= m_rvalid;
        if (m_rvalid) begin
          m_rd_e <= m_rdata; m_rl_e <= m_rlast; m_rid_e <= m_rid;
        end
      end
    end
  always @(negedge clock)
    if (rst_n) begin
      chk("model_s_arready", s_arready, (free_now && w_now >= 0) ? (64'd1 << w_now) : 64'd0);
      chk("model_m_arvalid", m_arvalid, m_arv);
      if (m_arv) begin
        chk("model_m_araddr", m_araddr, m_addr_e);
        chk("model_m_arlen", m_arlen, m_len_e);
        chk("model_m_arid", m_arid, m_id_e);
      end
      chk("model_s_rvalid", s_rvalid, m_rv ? (64'd1 << k_now) : 64'd0);
      if (m_rv) begin
        chk("model_s_rdata", s_rdata[k_now*DSIZE +: DSIZE], m_rd_e);
        chk("model_s_rlast", s_rlast[k_now], m_rl_e);
        chk("model_s_rid", s_rid[k_now*LAZISE +: LAZISE], m_rid_e[3:2]);
      end
      chk("model_m_rready", m_rready, rr_now);
    end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end
  initial begin
    int seq[6];
    seq = '{0, 1, 2, 3, 0, 1};
    s_arvalid = 0; s_araddr = 0; s_arlen = 0; s_arid = 0; m_arready = 1;
    m_rvalid = 0; m_rdata = 0; m_rlast = 0; m_rid = 0; s_rready = '1;
    for (int p = 0; p < NUM; p++) begin
      s_araddr[p*ASIZE +: ASIZE] = 32'h100 * p;
      s_arlen[p*LSIZE +: LSIZE]  = 8'(p + 1);
      s_arid[p*LAZISE +: LAZISE] = 2'(p);
    end
    repeat (2) tick();
    @(negedge clock);
    chk("reset_m_arvalid", m_arvalid, 0);
    chk("reset_s_rvalid", s_rvalid, 0);
    chk("reset_m_arid", m_arid, 0);
    rst_n = 1;
    tick();
    s_arvalid = '1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("rr_grant", s_arready, 64'd1 << seq[i]);
      if (i > 0) chk("rr_arid_port", m_arid[1:0], 64'(seq[i-1]));
      tick();
    end
    m_arready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("stall_s_arready", s_arready, 0);
      chk("stall_m_araddr", m_araddr, 32'h100);
      chk("stall_m_arid", m_arid, 4'h5);
      tick();
    end
    m_arready = 1;
    @(negedge clock);
    chk("resume_grant_p2", s_arready, 4'b0100);
    tick();
    @(negedge clock);
    chk("resume_grant_p3", s_arready, 4'b1000);
    tick();
    s_arvalid = 0;
    tick();
    s_arid[5:4] = 2'd3; s_araddr[95:64] = 32'h1000; s_arlen[23:16] = 8'd7; s_arvalid = 4'b0100;
    @(negedge clock);
    chk("p2_s_arready", s_arready, 4'b0100);
    tick();
    s_arvalid = 0;
    @(negedge clock);
    chk("p2_m_arvalid", m_arvalid, 1);
    chk("p2_m_arid", m_arid, 4'hE);
    chk("p2_m_araddr", m_araddr, 32'h1000);
    chk("p2_m_arlen", m_arlen, 8'd7);
    tick();
    m_rvalid = 1; m_rid = 4'b1101; m_rdata = 16'hAA; m_rlast = 1;
    tick();
    m_rvalid = 0; m_rlast = 0;
    @(negedge clock);
    chk("r_s_rvalid", s_rvalid, 4'b0010);
    chk("r_s_rid1", s_rid[3:2], 2'b11);
    chk("r_s_rdata1", s_rdata[31:16], 16'hAA);
    chk("r_s_rlast1", s_rlast[1], 1);
    tick();
    s_rready = 4'b1101; m_rvalid = 1; m_rid = 4'b0101; m_rdata = 16'h11;
    tick();
    m_rid = 4'b0011; m_rdata = 16'h33;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("hol_m_rready", m_rready, 0);
      chk("hol_s_rvalid", s_rvalid, 4'b0010);
      tick();
    end
    s_rready = '1;
    @(negedge clock);
    chk("hol_release_m_rready", m_rready, 1);
    tick();
    m_rvalid = 0;
    @(negedge clock);
    chk("hol_p3_s_rvalid", s_rvalid, 4'b1000);
    chk("hol_p3_s_rdata", s_rdata[63:48], 16'h33);
    tick();
    s_arvalid = '1; m_rvalid = 1; m_rid = 4'b0110; m_arready = 0;
    tick();
    tick();
    #2 rst_n = 0;
    #1;
    chk("async_rst_m_arvalid", m_arvalid, 0);
    chk("async_rst_s_rvalid", s_rvalid, 0);
    m_rvalid = 0; m_arready = 1;
    tick();
    rst_n = 1;
    @(negedge clock);
    chk("post_rst_grant_p0", s_arready, 4'b0001);
    tick();
    @(negedge clock);
    chk("post_rst_grant_p1", s_arready, 4'b0010);
    tick();
    s_arvalid = 0;
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
